// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// The ALU result is registered and held until the owning requester takes it;
// a new grant can replace a consumed response on the same edge.

package alu_pkg;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLT = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7
    } alu_op_t;
endpackage

// Purely combinational ALU; undefined op codes produce zero.
module alu
    import alu_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);
    // Operation select
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            OP_SLL:  result = a << b[4:0];
            OP_SRL:  result = a >> b[4:0];
            default: result = '0;
        endcase
    end

    assign zero = (result == 32'd0);
endmodule

module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  alu_op_t [NUM_REQ-1:0]       req_op,
    input  logic [NUM_REQ-1:0][31:0]    req_a,
    input  logic [NUM_REQ-1:0][31:0]    req_b,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [31:0]                 rsp_result,
    output logic                        rsp_zero,
    output logic [CNT_W-1:0]            op_count
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, RESP} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   rsp_id;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt_id;
    logic             gnt_found;
    logic             gnt;
    logic             rsp_take;
    logic             can_accept;
    logic [IDW:0]     idx;

    alu_op_t          alu_op;
    logic [31:0]      alu_a, alu_b, alu_res;
    logic             alu_zero;

    // The held response is consumed only by its owner's ready bit
    assign rsp_take   = (state == RESP) & rsp_ready[rsp_id];
    assign can_accept = (state == IDLE) | rsp_ready[rsp_id];

    // Round-robin search upward from rr_ptr, wrapping at NUM_REQ-1
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(NUM_REQ))
                idx = idx - (IDW+1)'(NUM_REQ);
            if (!gnt_found && req_valid[idx[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = idx[IDW-1:0];
            end
        end
    end

    assign gnt       = can_accept & gnt_found & ~rst;
    assign req_ready = gnt ? (NUM_REQ'(1) << gnt_id) : '0;

    // Granted requester's operands drive the single ALU
    assign alu_op = req_op[gnt_id];
    assign alu_a  = req_a[gnt_id];
    assign alu_b  = req_b[gnt_id];

    alu u_alu (
        .op     (alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_res),
        .zero   (alu_zero)
    );

    // Next-state: a grant always lands in RESP; a bare accept drains to IDLE
    always_comb begin
        state_nxt = state;
        if (gnt)
            state_nxt = RESP;
        else if (rsp_take)
            state_nxt = IDLE;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Response register, owner id and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_id     <= '0;
            rr_ptr     <= '0;
        end else if (gnt) begin
            rsp_valid  <= NUM_REQ'(1) << gnt_id;
            rsp_result <= alu_res;
            rsp_zero   <= alu_zero;
            rsp_id     <= gnt_id;
            rr_ptr     <= (gnt_id == IDW'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
        end else if (rsp_take) begin
            rsp_valid  <= '0;
        end
    end

    // Completed-op counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            op_count <= '0;
        else if (rsp_take)
            op_count <= op_count + 1'b1;
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter with a behavioural model.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N  = 2;
    localparam int CW = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid, req_ready, rsp_valid, rsp_ready;
    alu_op_t [N-1:0]      req_op;
    logic [N-1:0][31:0]   req_a, req_b;
    logic [31:0]          rsp_result;
    logic                 rsp_zero;
    logic [CW-1:0]        op_count;

    int n_assert = 0;
    int n_fail   = 0;

    // model state
    bit          m_pend;
    int          m_id, m_ptr, m_cnt;
    logic [31:0] m_res;
    bit          m_zero;

    alu_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_alu(int op, logic [31:0] a, logic [31:0] b);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6: return a << b[4:0];
            7: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_id = 0; m_ptr = 0; m_cnt = 0; m_res = 0; m_zero = 0;
    endtask

    // One clock: check against model at negedge, then advance model at posedge.
    task automatic cycle();
        int g;
        bit can, take;
        @(negedge clk);
        can = !m_pend || rsp_ready[m_id];
        g = -1;
        if (can)
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("rsp_valid", 32'(rsp_valid), m_pend ? (32'd1 << m_id) : 32'd0);
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_zero", 32'(rsp_zero), 32'(m_zero));
        chk("op_count", 32'(op_count), 32'(m_cnt));
        take = m_pend && rsp_ready[m_id];
        @(posedge clk);
        if (take) m_cnt = (m_cnt + 1) % (1 << CW);
        if (g >= 0) begin
            m_res  = ref_alu(int'(req_op[g]), req_a[g], req_b[g]);
            m_zero = (m_res == 0);
            m_id   = g;
            m_ptr  = (g + 1) % N;
            m_pend = 1;
        end else if (take) begin
            m_pend = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '1; rsp_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_op_count", 32'(op_count), 0);
        rst = 1'b0;
        req_valid = '0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; rsp_ready = '0;
        req_op = '{OP_ADD, OP_ADD}; req_a = '0; req_b = '0;
        model_reset();

        // 1: single ADD
        do_reset();
        req_op[0] = OP_ADD; req_a[0] = 32'd10; req_b[0] = 32'd20;
        req_valid = 2'b01; rsp_ready = 2'b01;
        #1 chk("t1_req_ready", 32'(req_ready), 32'b01);
        cycle();
        req_valid = 2'b00;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'b01);
        chk("t1_result", rsp_result, 32'd30);
        chk("t1_zero", 32'(rsp_zero), 0);
        cycle();
        chk("t1_op_count", 32'(op_count), 1);

        // 2: both requesters, alternate grants
        do_reset();
        req_op[0] = OP_SUB; req_a[0] = 32'd10;        req_b[0] = 32'd10;
        req_op[1] = OP_AND; req_a[1] = 32'hFF00FF00;  req_b[1] = 32'hFFFF0000;
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 chk("t2_grant", 32'(req_ready), (k % 2 == 0) ? 32'b01 : 32'b10);
            cycle();
            chk("t2_result", rsp_result, (k % 2 == 0) ? 32'd0 : 32'hFF000000);
            chk("t2_zero", 32'(rsp_zero), (k % 2 == 0) ? 1 : 0);
        end
        req_valid = 2'b00;
        cycle();

        // 3: backpressure on req0 blocks req1
        do_reset();
        req_op[0] = OP_SLT; req_a[0] = 32'hFFFFFFFB; req_b[0] = 32'd10;
        req_op[1] = OP_ADD; req_a[1] = 32'd1;        req_b[1] = 32'd2;
        req_valid = 2'b01; rsp_ready = 2'b00;
        cycle();
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_req_ready", 32'(req_ready), 0);
            chk("t3_rsp_valid", 32'(rsp_valid), 32'b01);
            chk("t3_result", rsp_result, 1);
            chk("t3_zero", 32'(rsp_zero), 0);
            cycle();
        end
        rsp_ready = 2'b01;
        #1 chk("t3_grant1", 32'(req_ready), 32'b10);
        cycle();
        chk("t3_rsp1", 32'(rsp_valid), 32'b10);
        chk("t3_res1", rsp_result, 32'd3);
        req_valid = 2'b00; rsp_ready = 2'b11;
        cycle();

        // 4: only req1 requesting
        do_reset();
        req_op[1] = OP_XOR; req_a[1] = 32'h1234; req_b[1] = 32'h00FF;
        req_valid = 2'b10; rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 chk("t4_grant", 32'(req_ready), 32'b10);
            cycle();
        end
        req_valid = 2'b00;
        cycle();
        chk("t4_op_count", 32'(op_count), 4);

        // 5: asynchronous reset while in RESP
        req_op[0] = OP_ADD; req_a[0] = 32'd7; req_b[0] = 32'd8;
        req_valid = 2'b01; rsp_ready = 2'b00;
        cycle();
        req_valid = 2'b00;
        chk("t5_pre_valid", 32'(rsp_valid), 32'b01);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_valid", 32'(rsp_valid), 0);
        chk("t5_async_result", rsp_result, 0);
        chk("t5_async_count", 32'(op_count), 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        req_op[1] = OP_OR; req_a[1] = 32'h10; req_b[1] = 32'h01;
        req_valid = 2'b11; rsp_ready = 2'b11;
        #1 chk("t5_first_grant", 32'(req_ready), 32'b01);
        cycle();
        req_valid = 2'b00;
        cycle();

        // 6: op_count wrap
        do_reset();
        req_valid = 2'b01; rsp_ready = 2'b01;
        for (int k = 0; k < 15; k++) begin
            req_op[0] = alu_op_t'(4'($urandom_range(0, 7)));
            req_a[0] = $urandom; req_b[0] = $urandom;
            cycle();
        end
        req_valid = 2'b00;
        cycle();
        chk("t6_count_max", 32'(op_count), 15);
        req_valid = 2'b01;
        cycle();
        req_valid = 2'b00;
        cycle();
        chk("t6_count_wrap", 32'(op_count), 0);

        // random traffic checked against the model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            req_valid = N'($urandom_range(0, 3));
            rsp_ready = N'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) begin
                req_op[i] = alu_op_t'(4'($urandom_range(0, 8)));
                req_a[i]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                req_b[i]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
